// File: rtl/dram_pkg.sv
// Shared constants and helpers for the dram_sdp scratch memory.
package dram_pkg;

  localparam int unsigned DRAM_BYTE_W = 8;
  localparam int unsigned RD_LAT_MAX  = 4;

  // Collision-mode selectors for the WR_FIRST parameter.
  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  function automatic int unsigned dram_lanes(input int unsigned data_w);
    return data_w / DRAM_BYTE_W;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Delay line for read beats {valid, err, data}; data only advances with valid
// so the tail holds the last delivered word.
module dram_rd_pipe
  import dram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STAGES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              err_o,
  output logic [DATA_W-1:0] data_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign valid_o = valid_i;
    assign err_o   = err_i;
    assign data_o  = data_i;
  end else begin : g_stages
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] err_q;
    logic [DATA_W-1:0] data_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        err_q   <= '0;
        for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
      end else begin
        valid_q[0] <= valid_i;
        err_q[0]   <= err_i;
        if (valid_i) data_q[0] <= data_i;
        for (int s = 1; s < STAGES; s++) begin
          valid_q[s] <= valid_q[s-1];
          err_q[s]   <= err_q[s-1];
          if (valid_q[s-1]) data_q[s] <= data_q[s-1];
        end
      end
    end

    assign valid_o = valid_q[STAGES-1];
    assign err_o   = err_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
  end

endmodule

// File: rtl/dram_sdp.sv
// Simple-dual-port scratch memory: byte-enabled writes, pipelined reads with
// valid strobe, selectable collision behaviour and out-of-range flag.
module dram_sdp
  import dram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DEPTH    = 1 << ADDR_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WR_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ren,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wbe,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     rerr
);

  localparam int unsigned LANES  = dram_lanes(DATA_W);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          WR_NEW = (WR_FIRST == dram_pkg::WR_FIRST);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("dram_sdp: RD_LAT must be in 1..%0d", RD_LAT_MAX);
  end
  if (DATA_W % DRAM_BYTE_W != 0) begin : g_bad_width
    $error("dram_sdp: DATA_W must be a multiple of %0d", DRAM_BYTE_W);
  end
  if (64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
    $error("dram_sdp: DEPTH exceeds 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              s0_valid_q, s0_valid_d;
  logic              s0_err_q,   s0_err_d;
  logic [DATA_W-1:0] s0_data_q,  s0_data_d;

  logic              rd_in_range_c;
  logic              wr_in_range_c;
  logic              wr_go_c;
  logic              collide_c;
  logic [IDX_W-1:0]  ridx_c;
  logic [IDX_W-1:0]  widx_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] merged_c;

  assign rd_in_range_c = 64'(raddr) < 64'(DEPTH);
  assign wr_in_range_c = 64'(waddr) < 64'(DEPTH);
  assign wr_go_c       = wen && wr_in_range_c;
  assign ridx_c        = raddr[IDX_W-1:0];
  assign widx_c        = waddr[IDX_W-1:0];
  assign collide_c     = wr_go_c && (raddr == waddr);

  // Array read plus the write-merged view used when write-first collides.
  always_comb begin
    rd_word_c = mem_q[ridx_c];
    merged_c  = rd_word_c;
    for (int i = 0; i < LANES; i++) begin
      if (wbe[i]) merged_c[i*DRAM_BYTE_W +: DRAM_BYTE_W] = wdata[i*DRAM_BYTE_W +: DRAM_BYTE_W];
    end
  end

  always_comb begin
    s0_valid_d = ren;
    s0_err_d   = ren && !rd_in_range_c;
    s0_data_d  = s0_data_q;
    if (ren) begin
      if (!rd_in_range_c)         s0_data_d = '0;
      else if (collide_c && WR_NEW) s0_data_d = merged_c;
      else                        s0_data_d = rd_word_c;
    end
  end

  // Array contents are deliberately outside the reset branch so they survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_err_q   <= s0_err_d;
      s0_data_q  <= s0_data_d;
      if (wr_go_c) begin
        for (int i = 0; i < LANES; i++) begin
          if (wbe[i]) mem_q[widx_c][i*DRAM_BYTE_W +: DRAM_BYTE_W] <= wdata[i*DRAM_BYTE_W +: DRAM_BYTE_W];
        end
      end
    end
  end

  dram_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT - 1)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s0_valid_q),
    .err_i   (s0_err_q),
    .data_i  (s0_data_q),
    .valid_o (rvalid),
    .err_o   (rerr),
    .data_o  (rdata)
  );

endmodule

// File: tb/tb_dram_sdp.sv
// Directed bench: A = 32b/RD_LAT1/read-first, B = 32b/RD_LAT3/write-first
// (shared inputs, DEPTH 16 in a 5-bit space), C = 8b/RD_LAT1 full 4-bit space.
module tb_dram_sdp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DP = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ren, wen;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    wbe;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, a_rerr, b_rvalid, b_rerr;

  logic          c_ren, c_wen;
  logic [3:0]    c_raddr, c_waddr;
  logic [7:0]    c_wdata, c_rdata;
  logic [0:0]    c_wbe;
  logic          c_rvalid, c_rerr;

  dram_sdp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RD_LAT(1), .WR_FIRST(0)) u_a (
    .clk(clk), .rst_n(rst_n), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .rdata(a_rdata), .rvalid(a_rvalid), .rerr(a_rerr));

  dram_sdp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RD_LAT(3), .WR_FIRST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .rdata(b_rdata), .rvalid(b_rvalid), .rerr(b_rerr));

  dram_sdp #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .ren(c_ren), .raddr(c_raddr), .wen(c_wen), .waddr(c_waddr),
    .wdata(c_wdata), .wbe(c_wbe), .rdata(c_rdata), .rvalid(c_rvalid), .rerr(c_rerr));

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        ren;
    logic [4:0]  raddr;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren = 1'b0; wen = 1'b0; raddr = '0; waddr = '0; wdata = '0; wbe = '0;
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [3:0] be, input logic r, input logic [4:0] ra,
                              input logic [31:0] ea, input logic [31:0] eb, input logic ee);
    vec_t t;
    t.wen = w; t.waddr = wa; t.wdata = wd; t.wbe = be;
    t.ren = r; t.raddr = ra; t.exp_a = ea; t.exp_b = eb; t.exp_err = ee;
    return t;
  endfunction

  initial begin
    //            wen waddr  wdata         wbe    ren raddr  exp_a (RD-first) exp_b (WR-first) err
    vecs.push_back(mk(1, 5'd5,  32'h11223344, 4'hF, 0, 5'd0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 5'd5,  32'hAABBCCDD, 4'h5, 0, 5'd0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 1, 5'd5,  32'h11BB33DD, 32'h11BB33DD, 0));
    vecs.push_back(mk(1, 5'd7,  32'h00000010, 4'hF, 0, 5'd0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 5'd7,  32'h00000020, 4'hF, 1, 5'd7,  32'h00000010, 32'h00000020, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 1, 5'd7,  32'h00000020, 32'h00000020, 0));
    vecs.push_back(mk(1, 5'd4,  32'hCAFEF00D, 4'hF, 0, 5'd0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 5'd20, 32'h00000055, 4'hF, 0, 5'd0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 1, 5'd4,  32'hCAFEF00D, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 1, 5'd20, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 5'd15, 32'h0F0F0F0F, 4'hF, 0, 5'd0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 1, 5'd15, 32'h0F0F0F0F, 32'h0F0F0F0F, 0));
    vecs.push_back(mk(1, 5'd15, 32'hFFFFFFFF, 4'h0, 0, 5'd0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 1, 5'd15, 32'h0F0F0F0F, 32'h0F0F0F0F, 0));
    vecs.push_back(mk(1, 5'd5,  32'h99887766, 4'hA, 1, 5'd5,  32'h11BB33DD, 32'h99BB77DD, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 1, 5'd5,  32'h99BB77DD, 32'h99BB77DD, 0));
    vecs.push_back(mk(1, 5'd20, 32'h12345678, 4'hF, 1, 5'd20, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 5'd3,  32'h00000033, 4'hF, 1, 5'd4,  32'hCAFEF00D, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0, 1, 5'd3,  32'h00000033, 32'h00000033, 0));

    rst_n = 1'b0;
    idle();
    c_ren = 1'b0; c_wen = 1'b0; c_raddr = '0; c_waddr = '0; c_wdata = '0; c_wbe = '0;
    tick(); tick();
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_rerr",   a_rerr,   0);
    chk("rst_a_rdata",  a_rdata,  0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_b_rdata",  b_rdata,  0);
    chk("rst_c_rvalid", c_rvalid, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wen = v.wen; waddr = v.waddr; wdata = v.wdata; wbe = v.wbe;
      ren = v.ren; raddr = v.raddr;
      tick();
      chk($sformatf("v%0d_a_rvalid", i), a_rvalid, v.ren);
      chk($sformatf("v%0d_a_rerr", i), a_rerr, v.ren & v.exp_err);
      if (v.ren) chk($sformatf("v%0d_a_rdata", i), a_rdata, v.exp_a);
      idle();
      tick();
      chk($sformatf("v%0d_a_strobe_1cyc", i), a_rvalid, 0);
      chk($sformatf("v%0d_b_early", i), b_rvalid, 0);
      tick();
      chk($sformatf("v%0d_b_rvalid", i), b_rvalid, v.ren);
      chk($sformatf("v%0d_b_rerr", i), b_rerr, v.ren & v.exp_err);
      if (v.ren) chk($sformatf("v%0d_b_rdata", i), b_rdata, v.exp_b);
    end

    // Preload 0..3 then four back-to-back reads.
    for (int k = 0; k < 4; k++) begin
      wen = 1'b1; waddr = 5'(k); wdata = 32'hA0 + 32'(k); wbe = 4'hF;
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      ren = 1'b1; raddr = 5'(k);
      tick();
      chk($sformatf("tp_a_rdata%0d", k), a_rdata, 32'hA0 + 32'(k));
      chk($sformatf("tp_a_rvalid%0d", k), a_rvalid, 1);
      if (k < 2) chk($sformatf("tp_b_idle%0d", k), b_rvalid, 0);
      else begin
        chk($sformatf("tp_b_rvalid%0d", k), b_rvalid, 1);
        chk($sformatf("tp_b_rdata%0d", k), b_rdata, 32'hA0 + 32'(k - 2));
      end
    end
    idle();
    tick();
    chk("tp_b_rvalid2", b_rvalid, 1);
    chk("tp_b_rdata2",  b_rdata,  32'hA2);
    tick();
    chk("tp_b_rvalid3", b_rvalid, 1);
    chk("tp_b_rdata3",  b_rdata,  32'hA3);
    tick();
    chk("tp_b_done",  b_rvalid, 0);
    chk("tp_b_hold",  b_rdata,  32'hA3);

    // Write after issue must not leak into an in-flight read.
    ren = 1'b1; raddr = 5'd0;
    tick();
    idle(); wen = 1'b1; waddr = 5'd0; wdata = 32'h5A; wbe = 4'hF;
    tick();
    idle();
    tick();
    chk("snap_b_rvalid", b_rvalid, 1);
    chk("snap_b_rdata",  b_rdata,  32'hA0);
    ren = 1'b1; raddr = 5'd0;
    tick();
    chk("snap_a_new", a_rdata, 32'h5A);
    idle();
    tick(); tick();
    chk("snap_b_new", b_rdata, 32'h5A);

    // Reset with two reads in flight; a write during reset is ignored.
    ren = 1'b1; raddr = 5'd1;
    tick();
    raddr = 5'd2;
    tick();
    idle(); wen = 1'b1; waddr = 5'd1; wdata = 32'h0000DEAD; wbe = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_b_rvalid", b_rvalid, 0);
    chk("rst_mid_b_rdata",  b_rdata,  0);
    chk("rst_mid_a_rvalid", a_rvalid, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_drop_b%0d", k), b_rvalid, 0);
    end
    ren = 1'b1; raddr = 5'd1;
    tick();
    chk("rst_keep_a", a_rdata, 32'hA1);
    idle();
    tick(); tick();
    chk("rst_keep_b_rvalid", b_rvalid, 1);
    chk("rst_keep_b", b_rdata, 32'hA1);

    // 8-bit instance: basic write/read, top address of a full power-of-two space.
    c_wen = 1'b1; c_waddr = 4'd0; c_wdata = 8'hFF; c_wbe = 1'b1;
    tick();
    c_wen = 1'b0; c_ren = 1'b1; c_raddr = 4'd0;
    tick();
    chk("c_rvalid", c_rvalid, 1);
    chk("c_rdata",  c_rdata,  8'hFF);
    chk("c_rerr",   c_rerr,   0);
    c_ren = 1'b0;
    tick();
    chk("c_idle", c_rvalid, 0);
    c_wen = 1'b1; c_waddr = 4'd15; c_wdata = 8'h3C;
    tick();
    c_wen = 1'b0; c_ren = 1'b1; c_raddr = 4'd15;
    tick();
    chk("c_top_rdata", c_rdata, 8'h3C);
    chk("c_top_rerr",  c_rerr,  0);
    c_ren = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
